// File: rtl/fifo_wr_framer_if.sv
// Stream-in / FIFO-write-out bundle for fifo_wr_framer.
//   s_valid/s_data/s_last/s_ready : upstream valid/ready byte stream with frame delimiter
//   w_full/w_inc/w_data           : FIFO write port (w_full registered in w_clk domain)
// master: the side that sources the stream and owns the FIFO (bench / system).
// slave : the framer itself.
interface fifo_wr_framer_if #(
  parameter int unsigned DATA_SIZE = 8
);
  logic                 s_valid;
  logic [DATA_SIZE-1:0] s_data;
  logic                 s_last;
  logic                 s_ready;
  logic                 w_full;
  logic                 w_inc;
  logic [DATA_SIZE-1:0] w_data;

  modport master (
    output s_valid, s_data, s_last, w_full,
    input  s_ready, w_inc, w_data
  );

  modport slave (
    input  s_valid, s_data, s_last, w_full,
    output s_ready, w_inc, w_data
  );
endinterface

// File: rtl/fifo_wr_framer.sv
// Write-domain front end of the async FIFO: 2-entry skid buffer, optional
// per-frame sequence-number header, FIFO write driver and saturating stats.
// Ports:
//   w_clk, wrst_n   : write clock, async active-low reset
//   bus (slave)     : upstream stream and FIFO write port
//   frame_seq       : sequence number carried by the next header
//   frame_cnt       : frames completed (last word written), saturating
//   word_cnt        : FIFO writes issued incl. headers, saturating
//   stall_cnt       : cycles with a write pending while w_full=1, saturating
module fifo_wr_framer #(
  parameter int unsigned DATA_SIZE = 8,
  parameter bit          HDR_EN    = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 w_clk,
  input  logic                 wrst_n,
  fifo_wr_framer_if.slave      bus,
  output logic [DATA_SIZE-1:0] frame_seq,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [CNT_W-1:0]     word_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_B = 2;

  typedef struct packed {
    logic                 last;
    logic [DATA_SIZE-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2
  } state_t;

  state_t               state_q, state_d;
  entry_t               mem_q [DEPTH];
  logic                 rd_ptr_q, wr_ptr_q;
  logic [CNT_B-1:0]     cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] frame_seq_q;
  logic [CNT_W-1:0]     frame_cnt_q, word_cnt_q, stall_cnt_q;

  logic                 push_c, pop_c, w_inc_c, stall_c, frame_done_c;
  logic [DATA_SIZE-1:0] w_data_c;
  entry_t               head_c;

  // s_ready comes from the occupancy register only, never from w_full
  assign bus.s_ready = (cnt_q != CNT_B'(DEPTH));
  assign push_c      = bus.s_valid && bus.s_ready;
  assign head_c      = mem_q[rd_ptr_q];

  // Next-state and write-port decode
  always_comb begin
    state_d      = state_q;
    w_inc_c      = 1'b0;
    w_data_c     = '0;
    pop_c        = 1'b0;
    stall_c      = 1'b0;
    frame_done_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cnt_q != '0) state_d = HDR_EN ? ST_HDR : ST_BODY;
      end
      ST_HDR: begin
        w_data_c = frame_seq_q;
        stall_c  = bus.w_full;
        if (!bus.w_full) begin
          w_inc_c = 1'b1;
          state_d = ST_BODY;
        end
      end
      ST_BODY: begin
        w_data_c = head_c.data;
        if (cnt_q != '0) begin
          stall_c = bus.w_full;
          if (!bus.w_full) begin
            w_inc_c = 1'b1;
            pop_c   = 1'b1;
            if (head_c.last) begin
              frame_done_c = 1'b1;
              state_d      = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Occupancy update; simultaneous push and pop cancel
  always_comb begin
    cnt_d = cnt_q;
    if (push_c && !pop_c)      cnt_d = cnt_q + CNT_B'(1);
    else if (!push_c && pop_c) cnt_d = cnt_q - CNT_B'(1);
  end

  // State register
  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Skid buffer storage and pointers
  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= '{last: bus.s_last, data: bus.s_data};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_c) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  // Sequence number and saturating statistics
  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      frame_seq_q <= '0;
      frame_cnt_q <= '0;
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (frame_done_c) begin
        frame_seq_q <= frame_seq_q + DATA_SIZE'(1);
        if (frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
      if (w_inc_c && (word_cnt_q != '1))  word_cnt_q  <= word_cnt_q + CNT_W'(1);
      if (stall_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.w_inc  = w_inc_c;
  assign bus.w_data = w_data_c;
  assign frame_seq  = frame_seq_q;
  assign frame_cnt  = frame_cnt_q;
  assign word_cnt   = word_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fifo_wr_framer.sv
// Directed bench for fifo_wr_framer: header DUT (a) and pass-through DUT (b).
module tb_fifo_wr_framer;

  logic w_clk  = 1'b0;
  logic wrst_n = 1'b0;
  always #5 w_clk = ~w_clk;

  fifo_wr_framer_if #(.DATA_SIZE(8)) ifa ();
  fifo_wr_framer_if #(.DATA_SIZE(8)) ifb ();

  logic [7:0]  seq_a, seq_b;
  logic [15:0] fcnt_a, wcnt_a, scnt_a, fcnt_b, wcnt_b, scnt_b;

  fifo_wr_framer #(.DATA_SIZE(8), .HDR_EN(1'b1), .CNT_W(16)) u_a (
    .w_clk(w_clk), .wrst_n(wrst_n), .bus(ifa),
    .frame_seq(seq_a), .frame_cnt(fcnt_a), .word_cnt(wcnt_a), .stall_cnt(scnt_a));

  fifo_wr_framer #(.DATA_SIZE(8), .HDR_EN(1'b0), .CNT_W(16)) u_b (
    .w_clk(w_clk), .wrst_n(wrst_n), .bus(ifb),
    .frame_seq(seq_b), .frame_cnt(fcnt_b), .word_cnt(wcnt_b), .stall_cnt(scnt_b));

  int n_asserts = 0;
  int n_fails   = 0;
  int ecnt      = 0;
  int viol_a    = 0;
  int viol_b    = 0;
  int last_acc  = 0;
  logic [7:0] qa_data[$];
  int         qa_edge[$];
  logic [7:0] qb_data[$];
  int         qb_edge[$];

  // Edge index of each rising edge
  always @(posedge w_clk) ecnt <= ecnt + 1;

  // Capture FIFO writes mid-cycle; stored edge is the one that performs the write
  always @(negedge w_clk) begin
    if (ifa.w_inc) begin
      qa_data.push_back(ifa.w_data);
      qa_edge.push_back(ecnt + 1);
      if (ifa.w_full) viol_a++;
    end
    if (ifb.w_inc) begin
      qb_data.push_back(ifb.w_data);
      qb_edge.push_back(ecnt + 1);
      if (ifb.w_full) viol_b++;
    end
  end

  task automatic clear_obs();
    qa_data.delete(); qa_edge.delete(); qb_data.delete(); qb_edge.delete();
    viol_a = 0; viol_b = 0;
  endtask

  task automatic do_reset();
    ifa.s_valid = 0; ifa.s_data = '0; ifa.s_last = 0; ifa.w_full = 0;
    ifb.s_valid = 0; ifb.s_data = '0; ifb.s_last = 0; ifb.w_full = 0;
    @(posedge w_clk); #2 wrst_n = 0;
    repeat (2) @(posedge w_clk);
    @(negedge w_clk) wrst_n = 1;
    @(posedge w_clk); #1;
    clear_obs();
  endtask

  // Present one word, hold until accepted; returns at posedge+1
  task automatic send_word(input bit sel, input logic [7:0] d, input logic l);
    int  n = 0;
    bit  acc = 0;
    logic rdy;
    if (sel) begin ifb.s_valid = 1; ifb.s_data = d; ifb.s_last = l; end
    else     begin ifa.s_valid = 1; ifa.s_data = d; ifa.s_last = l; end
    while (!acc) begin
      @(negedge w_clk);
      rdy = sel ? ifb.s_ready : ifa.s_ready;
      @(posedge w_clk); #1;
      if (rdy) acc = 1;
      else if (++n > 300) begin
        n_asserts++; n_fails++;
        $display("FAIL send_timeout: word %h not accepted after %0d cycles (need accept)", d, n);
        acc = 1;
      end
    end
    last_acc = ecnt;
    if (sel) ifb.s_valid = 0; else ifa.s_valid = 0;
  endtask

  task automatic wait_writes(input bit sel, input int n, input int budget);
    int k = 0;
    while (((sel ? qb_data.size() : qa_data.size()) < n) && (k < budget)) begin
      @(posedge w_clk); #1; k++;
    end
    repeat (6) begin @(posedge w_clk); #1; end
  endtask

  task automatic test_reset();
    logic [7:0] exp [2];
    exp[0] = 8'h00; exp[1] = 8'h77;
    #1;
    n_asserts++; if (ifa.s_ready !== 1'b1 || ifa.w_inc !== 1'b0 || ifa.w_data !== 8'h00) begin
      n_fails++; $display("FAIL reset_init_ports: s_ready=%b w_inc=%b w_data=%h, need 1 0 00", ifa.s_ready, ifa.w_inc, ifa.w_data); end
    n_asserts++; if (seq_a !== 8'h00 || fcnt_a !== 16'd0 || wcnt_a !== 16'd0 || scnt_a !== 16'd0) begin
      n_fails++; $display("FAIL reset_init_cnt: seq=%h f=%0d w=%0d s=%0d, need all 0", seq_a, fcnt_a, wcnt_a, scnt_a); end
    do_reset();
    // Fill buffer under full, let only the header out, then stall in BODY
    ifa.w_full = 1;
    send_word(0, 8'h55, 0);
    send_word(0, 8'h66, 0);
    ifa.w_full = 0;
    @(posedge w_clk); #1;
    ifa.w_full = 1;
    @(posedge w_clk); #1;
    n_asserts++; if (wcnt_a !== 16'd1 || ifa.s_ready !== 1'b0) begin
      n_fails++; $display("FAIL pre_reset_state: word_cnt=%0d s_ready=%b, need 1 0", wcnt_a, ifa.s_ready); end
    #3 wrst_n = 0;
    #1;
    n_asserts++; if (ifa.w_inc !== 1'b0 || ifa.s_ready !== 1'b1 || ifa.w_data !== 8'h00) begin
      n_fails++; $display("FAIL midframe_reset_ports: w_inc=%b s_ready=%b w_data=%h, need 0 1 00", ifa.w_inc, ifa.s_ready, ifa.w_data); end
    n_asserts++; if (seq_a !== 8'h00 || fcnt_a !== 16'd0 || wcnt_a !== 16'd0 || scnt_a !== 16'd0) begin
      n_fails++; $display("FAIL midframe_reset_cnt: seq=%h f=%0d w=%0d s=%0d, need all 0", seq_a, fcnt_a, wcnt_a, scnt_a); end
    ifa.w_full = 0;
    @(negedge w_clk) wrst_n = 1;
    @(posedge w_clk); #1;
    clear_obs();
    send_word(0, 8'h77, 1);
    wait_writes(0, 2, 50);
    n_asserts++; if (qa_data.size() !== 2) begin
      n_fails++; $display("FAIL post_reset_count: writes=%0d, need 2", qa_data.size()); end
    else for (int i = 0; i < 2; i++) begin
      n_asserts++; if (qa_data[i] !== exp[i]) begin
        n_fails++; $display("FAIL post_reset_word%0d: got %h, need %h", i, qa_data[i], exp[i]); end
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] exp [4];
    int acc0;
    exp[0] = 8'h00; exp[1] = 8'h11; exp[2] = 8'h22; exp[3] = 8'h33;
    do_reset();
    send_word(0, 8'h11, 0);
    acc0 = last_acc;
    send_word(0, 8'h22, 0);
    send_word(0, 8'h33, 1);
    wait_writes(0, 4, 50);
    n_asserts++; if (qa_data.size() !== 4) begin
      n_fails++; $display("FAIL single_count: writes=%0d, need 4", qa_data.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_asserts++; if (qa_data[i] !== exp[i] || qa_edge[i] !== acc0 + 2 + i) begin
          n_fails++; $display("FAIL single_word%0d: got %h at edge %0d, need %h at edge %0d",
                              i, qa_data[i], qa_edge[i], exp[i], acc0 + 2 + i); end
      end
    end
    n_asserts++; if (fcnt_a !== 16'd1 || wcnt_a !== 16'd4 || seq_a !== 8'h01) begin
      n_fails++; $display("FAIL single_cnt: frame=%0d word=%0d seq=%h, need 1 4 01", fcnt_a, wcnt_a, seq_a); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [6];
    logic rdy_full = 1'b1;
    for (int i = 0; i < 6; i++) exp[i] = 8'(i);
    do_reset();
    fork
      begin
        for (int i = 1; i <= 5; i++) send_word(0, 8'(i), (i == 5));
      end
      begin
        int n = 0;
        while (qa_data.size() < 2 && n < 100) begin @(negedge w_clk); n++; end
        @(posedge w_clk); #1 ifa.w_full = 1;
        for (int k = 0; k < 5; k++) begin
          @(negedge w_clk);
          if (k == 4) rdy_full = ifa.s_ready;
          @(posedge w_clk); #1;
        end
        ifa.w_full = 0;
      end
    join
    wait_writes(0, 6, 60);
    n_asserts++; if (viol_a !== 0) begin
      n_fails++; $display("FAIL bp_write_while_full: count=%0d, need 0", viol_a); end
    n_asserts++; if (rdy_full !== 1'b0) begin
      n_fails++; $display("FAIL bp_s_ready: got %b while stalled, need 0", rdy_full); end
    n_asserts++; if (scnt_a !== 16'd5) begin
      n_fails++; $display("FAIL bp_stall_cnt: got %0d, need 5", scnt_a); end
    n_asserts++; if (qa_data.size() !== 6 || wcnt_a !== 16'd6 || fcnt_a !== 16'd1) begin
      n_fails++; $display("FAIL bp_counts: writes=%0d word_cnt=%0d frame_cnt=%0d, need 6 6 1", qa_data.size(), wcnt_a, fcnt_a); end
    else for (int i = 0; i < 6; i++) begin
      n_asserts++; if (qa_data[i] !== exp[i]) begin
        n_fails++; $display("FAIL bp_word%0d: got %h, need %h", i, qa_data[i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [6];
    int gap;
    exp[0] = 8'h00; exp[1] = 8'hA0; exp[2] = 8'h01; exp[3] = 8'hA1; exp[4] = 8'h02; exp[5] = 8'hA2;
    do_reset();
    send_word(0, 8'hA0, 1);
    send_word(0, 8'hA1, 1);
    send_word(0, 8'hA2, 1);
    wait_writes(0, 6, 60);
    n_asserts++; if (qa_data.size() !== 6) begin
      n_fails++; $display("FAIL b2b_count: writes=%0d, need 6", qa_data.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        n_asserts++; if (qa_data[i] !== exp[i]) begin
          n_fails++; $display("FAIL b2b_word%0d: got %h, need %h", i, qa_data[i], exp[i]); end
      end
      // header->data adjacent; data->next header has one bubble
      for (int i = 1; i < 6; i++) begin
        gap = (i % 2 == 1) ? 1 : 2;
        n_asserts++; if (qa_edge[i] - qa_edge[i-1] !== gap) begin
          n_fails++; $display("FAIL b2b_gap%0d: got %0d edges, need %0d", i, qa_edge[i] - qa_edge[i-1], gap); end
      end
    end
  endtask

  task automatic test_seq_wrap();
    do_reset();
    for (int i = 0; i < 257; i++) send_word(0, 8'(i + 1), 1);
    wait_writes(0, 514, 200);
    n_asserts++; if (qa_data.size() !== 514) begin
      n_fails++; $display("FAIL wrap_count: writes=%0d, need 514", qa_data.size()); end
    else begin
      n_asserts++; if (qa_data[510] !== 8'hFF) begin
        n_fails++; $display("FAIL wrap_hdr256: got %h, need ff", qa_data[510]); end
      n_asserts++; if (qa_data[512] !== 8'h00) begin
        n_fails++; $display("FAIL wrap_hdr257: got %h, need 00", qa_data[512]); end
    end
    n_asserts++; if (fcnt_a !== 16'd257 || seq_a !== 8'h01 || wcnt_a !== 16'd514) begin
      n_fails++; $display("FAIL wrap_cnt: frame=%0d seq=%h word=%0d, need 257 01 514", fcnt_a, seq_a, wcnt_a); end
  endtask

  task automatic test_passthrough();
    logic [7:0] exp [40];
    int acc0 = 0;
    int lasts = 0;
    for (int i = 0; i < 40; i++) begin
      exp[i] = 8'(i * 37 + 5);
      if (i % 6 == 5 || i == 39) lasts++;
    end
    do_reset();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if (i != 0) repeat ($urandom_range(0, 2)) begin @(posedge w_clk); #1; end
          send_word(1, exp[i], (i % 6 == 5 || i == 39));
          if (i == 0) acc0 = last_acc;
        end
      end
      begin
        repeat (6) begin @(posedge w_clk); #1; end
        repeat (150) begin
          ifb.w_full = ($urandom_range(0, 2) == 0);
          @(posedge w_clk); #1;
        end
        ifb.w_full = 0;
      end
    join
    wait_writes(1, 40, 100);
    n_asserts++; if (viol_b !== 0) begin
      n_fails++; $display("FAIL pt_write_while_full: count=%0d, need 0", viol_b); end
    n_asserts++; if (qb_data.size() !== 40 || wcnt_b !== 16'd40) begin
      n_fails++; $display("FAIL pt_count: writes=%0d word_cnt=%0d, need 40 40", qb_data.size(), wcnt_b); end
    else begin
      n_asserts++; if (qb_edge[0] - acc0 !== 2) begin
        n_fails++; $display("FAIL pt_latency: got %0d edges, need 2", qb_edge[0] - acc0); end
      for (int i = 0; i < 40; i++) begin
        n_asserts++; if (qb_data[i] !== exp[i]) begin
          n_fails++; $display("FAIL pt_word%0d: got %h, need %h", i, qb_data[i], exp[i]); end
      end
    end
    n_asserts++; if (fcnt_b !== 16'(lasts) || seq_b !== 8'(lasts)) begin
      n_fails++; $display("FAIL pt_frames: frame_cnt=%0d seq=%0d, need %0d", fcnt_b, seq_b, lasts); end
  endtask

  initial begin
    ifa.s_valid = 0; ifa.s_data = '0; ifa.s_last = 0; ifa.w_full = 0;
    ifb.s_valid = 0; ifb.s_data = '0; ifb.s_last = 0; ifb.w_full = 0;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_seq_wrap();
    test_passthrough();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_framer.md
# fifo_wr_framer

Write-domain front end for the asynchronous FIFO. Accepts a valid/ready byte stream with frame delimiters, buffers it in a 2-entry skid buffer, optionally prefixes each frame with a sequence-number header word, and drives the FIFO write port (`w_data`, `w_inc`) while honouring the registered `w_full` flag. It also keeps write-side statistics counters for bring-up and verification.

## Interface
- `DATA_SIZE`, default 8: width of stream data, header word and FIFO write data.
- `HDR_EN`, default 1: 1 inserts a header word before each frame; 0 is pure pass-through.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `w_clk` input 1: write-domain clock; all state updates on its rising edge.
- `wrst_n` input 1: asynchronous, active-low reset.
- `s_valid` input 1: upstream word valid.
- `s_data` input `DATA_SIZE`: upstream word.
- `s_last` input 1: the word is the final word of its frame.
- `s_ready` output 1: block can accept a word this cycle.
- `w_full` input 1: FIFO full flag, registered in `w_clk` domain.
- `w_inc` output 1: FIFO write strobe.
- `w_data` output `DATA_SIZE`: FIFO write data.
- `frame_seq` output `DATA_SIZE`: sequence number the next header will carry.
- `frame_cnt` output `CNT_W`: frames completed (last word written), saturating.
- `word_cnt` output `CNT_W`: FIFO writes issued, headers included, saturating.
- `stall_cnt` output `CNT_W`: cycles with a write pending but `w_full`=1, saturating.

## Operation
- **Skid buffer:** 2-entry in-order queue of `{last, data}` with occupancy `cnt` (0..2).
  - `s_ready = (cnt != 2)`, derived from a register only; it never depends on `w_full` combinationally.
  - Push on `s_valid && s_ready`. Pop on a BODY-state write.
  - Push and pop in the same cycle leave `cnt` unchanged.
- **FSM states:**
  - **IDLE:** no write. If `cnt>0`, go to HDR when `HDR_EN`=1, else to BODY.
  - **HDR:** `w_data = frame_seq`. On `w_inc`, go to BODY.
  - **BODY:** `w_data` = buffer head data. When `w_inc` pops an entry with `last`=1: go to IDLE, increment `frame_seq` (wraps at 2^`DATA_SIZE`), and increment `frame_cnt`.
- **Write gating:** `w_inc = !w_full && ((state==HDR) || (state==BODY && cnt>0))`. No write is ever issued while `w_full`=1.
- **Between frames:** a frame's last word is followed by exactly one IDLE bubble cycle before the next header or body word.
- **Counters:** `word_cnt` increments on every `w_inc`. `stall_cnt` increments when a write is pending but `w_full`=1. All counters stick at all-ones.
- **Upstream `s_last`:** always obeyed. A 1-word frame is legal and gives header + 1 data word.
- **Reset (asynchronous, mid-frame included):**
  - state IDLE, `cnt`=0 with buffered entries discarded, `frame_seq`=0, all counters 0.
  - `s_ready`=1, `w_inc`=0, `w_data`=0.
  - A partially written frame is not completed after reset.

## Timing
- `w_inc` and `w_data` are combinational from registered state plus `w_full`. `w_data` is stable whenever `w_inc`=1.
- Latency with `HDR_EN`=1, from an accepted first word with the FIFO not full:
  - edge 0: word accepted; IDLE sees `cnt`=1.
  - edge 1: enter HDR; the header is written at edge 2.
  - data word 0 is written at edge 3.
- With `HDR_EN`=0, data word 0 is written at edge 2.
- Sustained throughput is 1 word/cycle within a frame while `w_full`=0.
- When `w_full` rises, `w_inc` drops in the same cycle. Upstream is backpressured (`s_ready`=0) after 2 further accepts at most.
- When `w_full` falls, writing resumes in that cycle with no lost or duplicated word.

## Test plan
- **Reset values:** pulse `wrst_n` low while the buffer holds 2 words in BODY -> immediately `w_inc`=0, `s_ready`=1, `frame_seq`=0, all counters 0. After release, the first frame carries header 0x00.
- **Single frame, `HDR_EN`=1, FIFO never full:** send 0x11, 0x22, 0x33 (last on 0x33) -> FIFO receives 0x00, 0x11, 0x22, 0x33 on consecutive cycles. Afterwards `frame_cnt`=1, `word_cnt`=4, `frame_seq`=1.
- **Backpressure:** hold `w_full`=1 for 5 cycles mid-frame -> `w_inc` is never asserted while full, `s_ready`=0 once 2 words are buffered, `stall_cnt`=5, and the output order is unchanged.
- **Back-to-back 1-word frames:** frames 0xA0, 0xA1, 0xA2 -> output 00, A0, 01, A1, 02, A2, with one idle cycle between frames.
- **Sequence wrap:** 257 frames with `DATA_SIZE`=8 -> the 257th header is 0x00 and `frame_cnt`=257.
- **Pass-through, `HDR_EN`=0, random `s_valid` and random `w_full`:** FIFO write stream equals the input stream exactly, and `word_cnt` equals the number of accepted words.
